// File: rtl/traffic_light_pkg.sv
// Shared types and defaults for the traffic light controller: state encoding,
// default phase durations and the phase rotation order.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    S_RED    = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2
  } state_e;

  localparam int DEF_RED_CYCLES    = 4;
  localparam int DEF_GREEN_CYCLES  = 4;
  localparam int DEF_YELLOW_CYCLES = 2;

  // Any encoding outside the three legal phases recovers to RED.
  function automatic state_e next_state(input state_e s);
    case (s)
      S_RED:    next_state = S_GREEN;
      S_GREEN:  next_state = S_YELLOW;
      S_YELLOW: next_state = S_RED;
      default:  next_state = S_RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_fsm_phase_timer.sv
// Phase timer: TW-bit up-counter that restarts at 0 on load and flags when the
// count reaches the current phase limit.
module phase_timer #(
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] limit,
  output logic          done
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + TW'(1);
    if (load) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done = (cnt_q == limit);

endmodule

// File: rtl/traffic_light_fsm.sv
// Three-phase Moore traffic light (RED -> GREEN -> YELLOW) with registered
// one-hot lamps. Define TRAFFIC_LIGHT_STATUS_EN to add state_o/remaining_o.
module traffic_light_fsm
  import traffic_light_pkg::*;
#(
  parameter int RED_CYCLES    = DEF_RED_CYCLES,
  parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
  parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
  localparam int MAX_CYCLES   = (RED_CYCLES > GREEN_CYCLES)
                                ? ((RED_CYCLES > YELLOW_CYCLES) ? RED_CYCLES : YELLOW_CYCLES)
                                : ((GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES),
  localparam int TW           = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic          red,
  output logic          green,
  output logic          yellow
`ifdef TRAFFIC_LIGHT_STATUS_EN
  ,
  output logic [1:0]    state_o,
  output logic [TW-1:0] remaining_o
`endif
);

  localparam logic [TW-1:0] RED_LIM    = TW'(RED_CYCLES - 1);
  localparam logic [TW-1:0] GREEN_LIM  = TW'(GREEN_CYCLES - 1);
  localparam logic [TW-1:0] YELLOW_LIM = TW'(YELLOW_CYCLES - 1);

  function automatic logic [TW-1:0] phase_limit(input state_e s);
    case (s)
      S_RED:    phase_limit = RED_LIM;
      S_GREEN:  phase_limit = GREEN_LIM;
      S_YELLOW: phase_limit = YELLOW_LIM;
      default:  phase_limit = '0;
    endcase
  endfunction

  state_e        state_q;
  state_e        state_d;
  logic          red_q, green_q, yellow_q;
  logic          timer_done;
  logic          bad_state;
  logic          load;
  logic [TW-1:0] limit;

  // An illegal encoding forces an immediate advance so the timer restarts too.
  always_comb begin
    limit     = phase_limit(state_q);
    bad_state = !(state_q inside {S_RED, S_GREEN, S_YELLOW});
    load      = timer_done | bad_state;
    state_d   = state_q;
    if (load) state_d = next_state(state_q);
  end

  phase_timer #(.TW(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .limit (limit),
    .done  (timer_done)
  );

  // Lamps are registered from the next state so they align with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RED;
      red_q    <= 1'b1;
      green_q  <= 1'b0;
      yellow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      red_q    <= (state_d == S_RED);
      green_q  <= (state_d == S_GREEN);
      yellow_q <= (state_d == S_YELLOW);
    end
  end

  assign red    = red_q;
  assign green  = green_q;
  assign yellow = yellow_q;

`ifdef TRAFFIC_LIGHT_STATUS_EN
  logic [TW-1:0] remaining_q;

  // Down-counter mirroring the timer: reloads at each phase boundary.
  always_ff @(posedge clk) begin
    if (reset)     remaining_q <= RED_LIM;
    else if (load) remaining_q <= phase_limit(state_d);
    else           remaining_q <= remaining_q - TW'(1);
  end

  assign state_o     = state_q;
  assign remaining_o = remaining_q;
`endif

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: vector table, hand sequences and random resets
// against a cycle-position model; a 1/1/1 instance runs alongside.
module tb_traffic_light_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic red, green, yellow;
  logic red1, green1, yellow1;
`ifdef TRAFFIC_LIGHT_STATUS_EN
  logic [1:0] state_o, state1_o;
  logic [1:0] remaining_o;
  logic [0:0] remaining1_o;
`endif

  always #5 clk = ~clk;

  traffic_light_fsm dut (
    .clk    (clk),
    .reset  (reset),
    .red    (red),
    .green  (green),
    .yellow (yellow)
`ifdef TRAFFIC_LIGHT_STATUS_EN
    ,
    .state_o     (state_o),
    .remaining_o (remaining_o)
`endif
  );

  traffic_light_fsm #(.RED_CYCLES(1), .GREEN_CYCLES(1), .YELLOW_CYCLES(1)) dut1 (
    .clk    (clk),
    .reset  (reset),
    .red    (red1),
    .green  (green1),
    .yellow (yellow1)
`ifdef TRAFFIC_LIGHT_STATUS_EN
    ,
    .state_o     (state1_o),
    .remaining_o (remaining1_o)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;
  int t       = 0;  // edges with reset low since the last reset edge

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
  endtask

  // Reference: position within the period decides the phase.
  function automatic void model(input int tt, input int r, input int g, input int y,
                                output logic [2:0] lamps, output int st, output int rem);
    int p;
    p = tt % (r + g + y);
    if (p < r) begin
      lamps = 3'b100; st = 0; rem = r - 1 - p;
    end else if (p < r + g) begin
      lamps = 3'b010; st = 1; rem = r + g - 1 - p;
    end else begin
      lamps = 3'b001; st = 2; rem = r + g + y - 1 - p;
    end
  endfunction

  task automatic step(input logic rst);
    reset = rst;
    @(posedge clk);
    #1;
    if (rst) t = 0;
    else     t++;
  endtask

  task automatic check_model();
    logic [2:0] l;
    int st, rem;
    model(t, 4, 4, 2, l, st, rem);
    chk("lamps", int'({red, green, yellow}), int'(l));
    chk("onehot", $countones({red, green, yellow}), 1);
`ifdef TRAFFIC_LIGHT_STATUS_EN
    chk("state_o", int'(state_o), st);
    chk("remaining_o", int'(remaining_o), rem);
`endif
    model(t, 1, 1, 1, l, st, rem);
    chk("lamps111", int'({red1, green1, yellow1}), int'(l));
`ifdef TRAFFIC_LIGHT_STATUS_EN
    chk("state111", int'(state1_o), st);
    chk("remaining111", int'(remaining1_o), rem);
`endif
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] exp_rgy;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [2:0] pat[10];
    logic [2:0] hand_exp[6];
    pat = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010,
            3'b010, 3'b010, 3'b010, 3'b001, 3'b001};

    // Reset 1 cycle, then 30 cycles of the R4 G4 Y2 pattern starting mid-RED.
    vecs.push_back('{1'b1, 3'b100});
    for (int i = 1; i <= 30; i++) vecs.push_back('{1'b0, pat[i % 10]});
    // Reset held 20 cycles keeps RED.
    for (int i = 0; i < 20; i++) vecs.push_back('{1'b1, 3'b100});
    for (int i = 1; i <= 12; i++) vecs.push_back('{1'b0, pat[i % 10]});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst);
      chk($sformatf("vec%0d", i), int'({red, green, yellow}), int'(vecs[i].exp_rgy));
      check_model();
    end

    // Reset during GREEN cycle 2, then a full RED phase before GREEN.
    step(1'b1);
    for (int i = 0; i < 5; i++) step(1'b0);
    chk("green_cycle2", int'({red, green, yellow}), 3'b010);
    hand_exp = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b010};
    step(1'b1);
    chk("mid_reset", int'({red, green, yellow}), int'(hand_exp[0]));
    for (int i = 1; i < 6; i++) begin
      step(1'b0);
      chk($sformatf("after_reset%0d", i), int'({red, green, yellow}), int'(hand_exp[i]));
    end

    // 1/1/1 rotation by hand.
    step(1'b1);
    chk("rot_r0", int'({red1, green1, yellow1}), 3'b100);
    step(1'b0);
    chk("rot_g", int'({red1, green1, yellow1}), 3'b010);
    step(1'b0);
    chk("rot_y", int'({red1, green1, yellow1}), 3'b001);
    step(1'b0);
    chk("rot_r1", int'({red1, green1, yellow1}), 3'b100);

    // Random resets sprinkled over a long run.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 24) == 0);
      check_model();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
